// File: rtl/pdp_mem_responder.sv
// pdp_mem_responder: 4K x 12 word store serving the PDP-8 IFU read port, the
// execute read port and the execute write port.
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   ifu_rd_req/addr -> ifu_rd_data/valid     IFU read, RD_LATENCY cycles
//   exec_rd_req/addr -> exec_rd_data/valid   execute read, RD_LATENCY cycles
//   exec_wr_req/addr/data               execute write (ignored in reset)
//   load_en/addr/data                   preload write (honored only in reset)
//   ifu_rd_cnt, exec_rd_cnt, exec_wr_cnt     wrapping accepted-access counters
module pdp_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_valid,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_valid,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [CNT_WIDTH-1:0]  ifu_rd_cnt,
  output logic [CNT_WIDTH-1:0]  exec_rd_cnt,
  output logic [CNT_WIDTH-1:0]  exec_wr_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [RD_LATENCY-1:0] r_ifu_vld;
  logic [RD_LATENCY-1:0] r_exe_vld;
  logic [DATA_WIDTH-1:0] r_ifu_dat     [RD_LATENCY];
  logic [DATA_WIDTH-1:0] r_exe_dat     [RD_LATENCY];
  logic [DATA_WIDTH-1:0] w_ifu_dat_nxt [RD_LATENCY];
  logic [DATA_WIDTH-1:0] w_exe_dat_nxt [RD_LATENCY];

  logic [CNT_WIDTH-1:0] r_ifu_cnt;
  logic [CNT_WIDTH-1:0] r_exe_cnt;
  logic [CNT_WIDTH-1:0] r_wr_cnt;

  logic [DATA_WIDTH-1:0] w_ifu_word;
  logic [DATA_WIDTH-1:0] w_exe_word;

  // Array is never reset; reset_n level selects preload vs. execute write,
  // so a write during reset is dropped and a preload always wins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      if (load_en) r_mem[load_addr] <= load_data;
    end else if (exec_wr_req) begin
      r_mem[exec_wr_addr] <= exec_wr_data;
    end
  end

  // Same-edge write to the read address is forwarded to the reader.
  assign w_ifu_word = (exec_wr_req && (exec_wr_addr == ifu_rd_addr)) ?
                      exec_wr_data : r_mem[ifu_rd_addr];
  assign w_exe_word = (exec_wr_req && (exec_wr_addr == exec_rd_addr)) ?
                      exec_wr_data : r_mem[exec_rd_addr];

  // Data stages only load when a valid word arrives, so the last stage holds
  // the most recent response while valid is low.
  for (genvar k = 0; k < RD_LATENCY; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_ifu_dat_nxt[k] = ifu_rd_req  ? w_ifu_word : r_ifu_dat[k];
      assign w_exe_dat_nxt[k] = exec_rd_req ? w_exe_word : r_exe_dat[k];
    end else begin : g_tail
      assign w_ifu_dat_nxt[k] = r_ifu_vld[k-1] ? r_ifu_dat[k-1] : r_ifu_dat[k];
      assign w_exe_dat_nxt[k] = r_exe_vld[k-1] ? r_exe_dat[k-1] : r_exe_dat[k];
    end
  end

  // Read pipelines; reset discards anything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ifu_vld <= '0;
      r_exe_vld <= '0;
      r_ifu_dat <= '{default: '0};
      r_exe_dat <= '{default: '0};
    end else begin
      r_ifu_vld <= RD_LATENCY'({r_ifu_vld, ifu_rd_req});
      r_exe_vld <= RD_LATENCY'({r_exe_vld, exec_rd_req});
      r_ifu_dat <= w_ifu_dat_nxt;
      r_exe_dat <= w_exe_dat_nxt;
    end
  end

  // Accepted-access counters, free-running modulo 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ifu_cnt <= '0;
      r_exe_cnt <= '0;
      r_wr_cnt  <= '0;
    end else begin
      if (ifu_rd_req)  r_ifu_cnt <= r_ifu_cnt + CNT_WIDTH'(1);
      if (exec_rd_req) r_exe_cnt <= r_exe_cnt + CNT_WIDTH'(1);
      if (exec_wr_req) r_wr_cnt  <= r_wr_cnt  + CNT_WIDTH'(1);
    end
  end

  assign ifu_rd_valid  = r_ifu_vld[RD_LATENCY-1];
  assign ifu_rd_data   = r_ifu_dat[RD_LATENCY-1];
  assign exec_rd_valid = r_exe_vld[RD_LATENCY-1];
  assign exec_rd_data  = r_exe_dat[RD_LATENCY-1];
  assign ifu_rd_cnt    = r_ifu_cnt;
  assign exec_rd_cnt   = r_exe_cnt;
  assign exec_wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_pdp_mem_responder.sv
// Bench for pdp_mem_responder: three instances (latency 1, 3 and 2; the
// latency-2 one has 4-bit counters) share one stimulus stream and are checked
// every cycle against a timestamped request history and a word-array model.
module tb_pdp_mem_responder;

  localparam int HN = 8192;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifu_req, exe_req, wr_req, load_en;
  logic [11:0] ifu_addr, exe_addr, wr_addr, wr_data, load_addr, load_data;

  logic        o_iv [3];
  logic        o_ev [3];
  logic [11:0] o_id [3];
  logic [11:0] o_ed [3];
  logic [15:0] o_ic [2];
  logic [15:0] o_ec [2];
  logic [15:0] o_wc [2];
  logic [3:0]  s_ic, s_ec, s_wc;

  always #5 clk = ~clk;

  pdp_mem_responder #(.RD_LATENCY(1), .CNT_WIDTH(16)) u_l1 (
    .clk(clk), .reset_n(reset_n),
    .ifu_rd_req(ifu_req), .ifu_rd_addr(ifu_addr),
    .ifu_rd_data(o_id[0]), .ifu_rd_valid(o_iv[0]),
    .exec_rd_req(exe_req), .exec_rd_addr(exe_addr),
    .exec_rd_data(o_ed[0]), .exec_rd_valid(o_ev[0]),
    .exec_wr_req(wr_req), .exec_wr_addr(wr_addr), .exec_wr_data(wr_data),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .ifu_rd_cnt(o_ic[0]), .exec_rd_cnt(o_ec[0]), .exec_wr_cnt(o_wc[0]));

  pdp_mem_responder #(.RD_LATENCY(3), .CNT_WIDTH(16)) u_l3 (
    .clk(clk), .reset_n(reset_n),
    .ifu_rd_req(ifu_req), .ifu_rd_addr(ifu_addr),
    .ifu_rd_data(o_id[1]), .ifu_rd_valid(o_iv[1]),
    .exec_rd_req(exe_req), .exec_rd_addr(exe_addr),
    .exec_rd_data(o_ed[1]), .exec_rd_valid(o_ev[1]),
    .exec_wr_req(wr_req), .exec_wr_addr(wr_addr), .exec_wr_data(wr_data),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .ifu_rd_cnt(o_ic[1]), .exec_rd_cnt(o_ec[1]), .exec_wr_cnt(o_wc[1]));

  pdp_mem_responder #(.RD_LATENCY(2), .CNT_WIDTH(4)) u_l2 (
    .clk(clk), .reset_n(reset_n),
    .ifu_rd_req(ifu_req), .ifu_rd_addr(ifu_addr),
    .ifu_rd_data(o_id[2]), .ifu_rd_valid(o_iv[2]),
    .exec_rd_req(exe_req), .exec_rd_addr(exe_addr),
    .exec_rd_data(o_ed[2]), .exec_rd_valid(o_ev[2]),
    .exec_wr_req(wr_req), .exec_wr_addr(wr_addr), .exec_wr_data(wr_data),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .ifu_rd_cnt(s_ic), .exec_rd_cnt(s_ec), .exec_wr_cnt(s_wc));

  // Reference model: word array plus per-edge request history.
  logic [11:0] m_mem [4096];
  bit          hv_i [HN];
  bit          hv_e [HN];
  logic [11:0] hd_i [HN];
  logic [11:0] hd_e [HN];
  logic [11:0] held_i [3];
  logic [11:0] held_e [3];
  int          lat [3] = '{1, 3, 2};
  int          cyc, cnt_i, cnt_e, cnt_w;
  int          checks, errors;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int  idx;
      bit  evi, eve;
      idx = cyc - lat[k] + 1;
      evi = (idx >= 0) ? hv_i[idx] : 1'b0;
      eve = (idx >= 0) ? hv_e[idx] : 1'b0;
      if (evi) held_i[k] = hd_i[idx];
      if (eve) held_e[k] = hd_e[idx];
      chk($sformatf("c%0d_u%0d_ifu_valid", cyc, k), 16'(o_iv[k]), 16'(evi));
      chk($sformatf("c%0d_u%0d_ifu_data", cyc, k), 16'(o_id[k]), 16'(held_i[k]));
      chk($sformatf("c%0d_u%0d_exe_valid", cyc, k), 16'(o_ev[k]), 16'(eve));
      chk($sformatf("c%0d_u%0d_exe_data", cyc, k), 16'(o_ed[k]), 16'(held_e[k]));
      if (k < 2) begin
        chk($sformatf("c%0d_u%0d_ifu_cnt", cyc, k), o_ic[k], 16'(cnt_i));
        chk($sformatf("c%0d_u%0d_exe_cnt", cyc, k), o_ec[k], 16'(cnt_e));
        chk($sformatf("c%0d_u%0d_wr_cnt", cyc, k),  o_wc[k], 16'(cnt_w));
      end else begin
        chk($sformatf("c%0d_u2_ifu_cnt", cyc), 16'(s_ic), 16'(cnt_i % 16));
        chk($sformatf("c%0d_u2_exe_cnt", cyc), 16'(s_ec), 16'(cnt_e % 16));
        chk($sformatf("c%0d_u2_wr_cnt", cyc),  16'(s_wc), 16'(cnt_w % 16));
      end
    end
  endtask

  // Apply the current inputs to the model, advance one edge, check.
  task automatic step();
    int n;
    n = cyc + 1;
    if (n >= HN) begin
      $display("FAIL history_overflow observed=%0d expected<%0d", n, HN);
      $fatal(1, "history overflow");
    end
    hv_i[n] = 1'b0;
    hv_e[n] = 1'b0;
    if (reset_n) begin
      if (ifu_req) begin
        hv_i[n] = 1'b1;
        hd_i[n] = (wr_req && wr_addr == ifu_addr) ? wr_data : m_mem[ifu_addr];
        cnt_i++;
      end
      if (exe_req) begin
        hv_e[n] = 1'b1;
        hd_e[n] = (wr_req && wr_addr == exe_addr) ? wr_data : m_mem[exe_addr];
        cnt_e++;
      end
      if (wr_req) begin
        m_mem[wr_addr] = wr_data;
        cnt_w++;
      end
    end else if (load_en) begin
      m_mem[load_addr] = load_data;
    end
    @(posedge clk);
    #1;
    cyc = n;
    check_all();
  endtask

  task automatic idle();
    ifu_req = 1'b0; exe_req = 1'b0; wr_req = 1'b0; load_en = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < HN; i++) begin
      hv_i[i] = 1'b0;
      hv_e[i] = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      held_i[k] = '0;
      held_e[k] = '0;
    end
    cnt_i = 0; cnt_e = 0; cnt_w = 0;
  endtask

  task automatic rand_cycles(input int num);
    for (int i = 0; i < num; i++) begin
      ifu_req  = 1'($urandom);
      exe_req  = 1'($urandom);
      wr_req   = 1'($urandom);
      load_en  = 1'($urandom);
      ifu_addr = 12'($urandom_range(0, 15)) + 12'h040;
      exe_addr = 12'($urandom_range(0, 15)) + 12'h040;
      wr_addr  = 12'($urandom_range(0, 15)) + 12'h040;
      wr_data  = 12'($urandom);
      load_addr = 12'($urandom);
      load_data = 12'($urandom);
      step();
    end
    idle();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    reset_n = 1'b0;
    idle();
    ifu_addr = '0; exe_addr = '0; wr_addr = '0; wr_data = '0;
    load_addr = '0; load_data = '0;
    model_reset();
    #1;
    check_all();

    // Preload every word; read/write requests under reset must be ignored.
    for (int a = 0; a < 4096; a++) begin
      load_en   = 1'b1;
      load_addr = 12'(a);
      case (a)
        12'h080: load_data = 12'o7200;
        12'h100: load_data = 12'o1234;
        12'h200: load_data = 12'd5;
        default: load_data = 12'($urandom);
      endcase
      ifu_req  = 1'($urandom);  ifu_addr = 12'($urandom);
      exe_req  = 1'($urandom);  exe_addr = 12'($urandom);
      wr_req   = 1'($urandom);  wr_addr  = 12'($urandom);
      wr_data  = 12'($urandom);
      step();
    end

    // Load beats a simultaneous write; a lone write under reset is dropped.
    load_en = 1'b1; load_addr = 12'h300; load_data = 12'h555;
    wr_req = 1'b1; wr_addr = 12'h300; wr_data = 12'hAAA;
    ifu_req = 1'b0; exe_req = 1'b0;
    step();
    load_en = 1'b0; wr_addr = 12'h301;
    step();

    // First edge after release: fetch preloaded instruction.
    idle();
    reset_n = 1'b1;
    load_en = 1'b1; load_addr = 12'h080; load_data = 12'h000;
    ifu_req = 1'b1; ifu_addr = 12'h080;
    step();
    chk("fetch_valid", 16'(o_iv[0]), 16'd1);
    chk("fetch_data", 16'(o_id[0]), 16'(12'o7200));
    chk("fetch_cnt", o_ic[0], 16'd1);
    idle();

    ifu_req = 1'b1; ifu_addr = 12'h300;
    exe_req = 1'b1; exe_addr = 12'h301;
    step();
    chk("load_wins", 16'(o_id[0]), 16'h555);
    idle();
    step();

    // Forwarding to both read ports.
    ifu_req = 1'b1; ifu_addr = 12'h100;
    exe_req = 1'b1; exe_addr = 12'h100;
    wr_req = 1'b1; wr_addr = 12'h100; wr_data = 12'o4321;
    step();
    chk("fwd_exe", 16'(o_ed[0]), 16'(12'o4321));
    chk("fwd_ifu", 16'(o_id[0]), 16'(12'o4321));
    chk("fwd_wr_cnt", o_wc[0], 16'd1);
    idle();
    step();
    exe_req = 1'b1; exe_addr = 12'h100;
    step();
    chk("fwd_later", 16'(o_ed[0]), 16'(12'o4321));
    idle();

    // Dual-port streaming.
    for (int i = 0; i < 16; i++) begin
      ifu_req = 1'b1; ifu_addr = 12'(i);
      exe_req = 1'b1; exe_addr = 12'hFF0 + 12'(i);
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) step();

    // In-flight response is unaffected by a later write.
    exe_req = 1'b1; exe_addr = 12'h200;
    step();
    idle();
    wr_req = 1'b1; wr_addr = 12'h200; wr_data = 12'd7;
    step();
    chk("inflight_valid", 16'(o_ev[2]), 16'd1);
    chk("inflight_data", 16'(o_ed[2]), 16'd5);
    idle();
    for (int i = 0; i < 3; i++) step();

    rand_cycles(300);
    for (int i = 0; i < 4; i++) step();

    // Async reset with reads in flight.
    ifu_req = 1'b1; ifu_addr = 12'h080;
    exe_req = 1'b1; exe_addr = 12'h100;
    step();
    step();
    idle();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_l3_ifu_valid", 16'(o_iv[1]), 16'd0);
    chk("rst_l3_exe_valid", 16'(o_ev[1]), 16'd0);
    chk("rst_wr_cnt", o_wc[0], 16'd0);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    exe_req = 1'b1; exe_addr = 12'h100;
    step();
    chk("preserved", 16'(o_ed[0]), 16'(12'o4321));
    idle();
    step();

    // Counter wrap on the 4-bit instance.
    for (int i = 0; i < 17; i++) begin
      wr_req = 1'b1; wr_addr = 12'h400 + 12'(i % 16); wr_data = 12'($urandom);
      step();
    end
    idle();
    chk("wrap_u2", 16'(s_wc), 16'd1);
    chk("wrap_u1", o_wc[0], 16'd17);

    rand_cycles(100);
    for (int i = 0; i < 4; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
